wheel_speed_meas: RTL

Measures wheel rotation from a single Hall/reed sensor pulse per revolution and produces the speed and period values consumed by the LCD1602 display stage. It synchronises and debounces the sensor and counts clk cycles between consecutive debounced rising edges. A serial divider converts each period to integer speed. Outputs are held stable between updates so the display stage can sample them at any time.

---
 rtl/wheel_speed_meas_if.sv | 11 +
 rtl/wheel_speed_meas.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/wheel_speed_meas_if.sv
// Measurement bundle from wheel_speed_meas to the LCD1602 display stage.
// The meter drives the master side; the display samples the slave side at any time.
interface wheel_speed_meas_if;
  logic [7:0]  velo;
  logic [31:0] peri_num;
  logic        meas_valid;
  logic        stalled;

  modport master (output velo, peri_num, meas_valid, stalled);
  modport slave  (input  velo, peri_num, meas_valid, stalled);
endinterface

// File: rtl/wheel_speed_meas.sv
// Wheel speed meter: sync + debounce of a once-per-revolution sensor, period count, serial divide to m/s.
// Optional macro WHEEL_AVG_EN: report the mean of the last four valid periods instead of the raw period.
module wheel_speed_meas #(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned CIRC_MM     = 2000,
  parameter int unsigned DEB_CYC     = 5000,
  parameter int unsigned TIMEOUT_CYC = 200_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sensor_in,
  wheel_speed_meas_if.master meas
);

  localparam logic [63:0] VEL_K_64 = 64'(CLK_HZ) * 64'(CIRC_MM) / 64'd1000;
  localparam logic [31:0] VEL_K    = VEL_K_64[31:0];
  localparam logic [31:0] DEB_M1   = 32'(DEB_CYC - 1);
  localparam logic [31:0] TMO      = 32'(TIMEOUT_CYC);

  typedef enum logic { WAIT_FIRST, RUN } fsm_e;
  typedef enum logic [1:0] { D_IDLE, D_RUN, D_DONE } div_e;

  // Input path
  logic [1:0]  sync_q, sync_d;
  logic        deb_level_q, deb_level_d;
  logic [31:0] deb_cnt_q, deb_cnt_d;
  logic        edge_q, edge_d;

  // Period measurement and control
  logic [31:0] period_q, period_d;
  fsm_e        state_q, state_d;
  logic        meas_edge, timeout;

  // Serial divider
  div_e        div_state_q, div_state_d;
  logic [4:0]  div_cnt_q, div_cnt_d;
  logic [31:0] div_rem_q, div_rem_d;
  logic [31:0] div_quo_q, div_quo_d;
  logic [31:0] div_den_q, div_den_d;
  logic [32:0] div_trial;
  logic        div_start;
  logic [31:0] div_arg;

  // Registered outputs
  logic [7:0]  velo_q, velo_d;
  logic [31:0] peri_q, peri_d;
  logic        valid_q, valid_d;
  logic        stalled_q, stalled_d;

  // NOTE: every signal written in an always_comb gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    sync_d      = {sync_q[0], sensor_in};
    deb_level_d = deb_level_q;
    deb_cnt_d   = '0;
    edge_d      = 1'b0;
    // A single agreeing cycle drops the count back to zero.
    if (sync_q[1] != deb_level_q) begin
      if (deb_cnt_q == DEB_M1) begin
        deb_level_d = sync_q[1];
        edge_d      = sync_q[1];
      end else begin
        deb_cnt_d = deb_cnt_q + 32'd1;
      end
    end
  end

`ifdef WHEEL_AVG_EN
  logic [31:0] hist_q [4];
  logic [31:0] hist_d [4];
  logic [2:0]  hist_cnt_q, hist_cnt_d;
  logic        mean_pend_q, mean_pend_d;
  logic [33:0] hist_sum;
  logic [31:0] mean;

  always_comb begin
    hist_d      = hist_q;
    hist_cnt_d  = hist_cnt_q;
    mean_pend_d = 1'b0;
    if (timeout) begin
      for (int i = 0; i < 4; i++) hist_d[i] = '0;
      hist_cnt_d = '0;
    end else if (meas_edge) begin
      hist_d[3]   = hist_q[2];
      hist_d[2]   = hist_q[1];
      hist_d[1]   = hist_q[0];
      hist_d[0]   = period_q;
      hist_cnt_d  = (hist_cnt_q == 3'd4) ? 3'd4 : hist_cnt_q + 3'd1;
      mean_pend_d = 1'b1;
    end
  end

  // Empty slots are zero, so the plain sum is correct for a partially filled history.
  always_comb begin
    hist_sum = {2'b00, hist_q[0]} + {2'b00, hist_q[1]} + {2'b00, hist_q[2]} + {2'b00, hist_q[3]};
    case (hist_cnt_q)
      3'd2:    mean = hist_sum[32:1];
      3'd3:    mean = 32'(hist_sum / 34'd3);
      3'd4:    mean = hist_sum[33:2];
      default: mean = hist_sum[31:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the history is reset explicitly because the mean adds all four slots and relies on unused ones being zero.
      for (int i = 0; i < 4; i++) hist_q[i] <= '0;
      hist_cnt_q  <= '0;
      mean_pend_q <= 1'b0;
    end else begin
      hist_q      <= hist_d;
      hist_cnt_q  <= hist_cnt_d;
      mean_pend_q <= mean_pend_d;
    end
  end

  // One extra cycle forms the mean before the divide starts.
  assign div_start = mean_pend_q;
  assign div_arg   = mean;
`else
  assign div_start = meas_edge;
  assign div_arg   = period_q;
`endif

  always_comb begin
    meas_edge = (state_q == RUN) && edge_q && (period_q < TMO);
    timeout   = (state_q == RUN) && !meas_edge && (period_q >= TMO);

    state_d = state_q;
    case (state_q)
      WAIT_FIRST: if (edge_q)  state_d = RUN;
      RUN:        if (timeout) state_d = WAIT_FIRST;
      default:    state_d = WAIT_FIRST;
    endcase

    if (edge_q)              period_d = 32'd1;
    else if (period_q < TMO) period_d = period_q + 32'd1;
    else                     period_d = period_q;
  end

  always_comb begin
    div_state_d = div_state_q;
    div_cnt_d   = div_cnt_q;
    div_rem_d   = div_rem_q;
    div_quo_d   = div_quo_q;
    div_den_d   = div_den_q;
    div_trial   = {div_rem_q, div_quo_q[31]};

    velo_d    = velo_q;
    peri_d    = peri_q;
    valid_d   = 1'b0;
    stalled_d = stalled_q;

    if (timeout) begin
      div_state_d = D_IDLE;
      velo_d      = 8'd0;
      peri_d      = TMO;
      stalled_d   = 1'b1;
      valid_d     = 1'b1;
    end else if (div_start) begin
      // A new period aborts any divide in flight; only its result will be reported.
      div_state_d = D_RUN;
      div_cnt_d   = '0;
      div_rem_d   = '0;
      div_quo_d   = VEL_K;
      div_den_d   = div_arg;
      peri_d      = div_arg;
      stalled_d   = 1'b0;
    end else begin
      case (div_state_q)
        D_RUN: begin
          if (div_trial >= {1'b0, div_den_q}) begin
            div_rem_d = 32'(div_trial - {1'b0, div_den_q});
            div_quo_d = {div_quo_q[30:0], 1'b1};
          end else begin
            div_rem_d = div_trial[31:0];
            div_quo_d = {div_quo_q[30:0], 1'b0};
          end
          div_cnt_d = div_cnt_q + 5'd1;
          if (div_cnt_q == 5'd31) div_state_d = D_DONE;
        end
        D_DONE: begin
          div_state_d = D_IDLE;
          valid_d     = 1'b1;
          velo_d      = (div_den_q < 32'd2 || div_quo_q > 32'd255) ? 8'd255 : div_quo_q[7:0];
        end
        default: div_state_d = D_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      deb_level_q <= 1'b0;
      deb_cnt_q   <= '0;
      edge_q      <= 1'b0;
      period_q    <= '0;
      state_q     <= WAIT_FIRST;
      div_state_q <= D_IDLE;
      div_cnt_q   <= '0;
      div_rem_q   <= '0;
      div_quo_q   <= '0;
      div_den_q   <= '0;
      velo_q      <= '0;
      peri_q      <= '0;
      valid_q     <= 1'b0;
      stalled_q   <= 1'b1;
    end else begin
      sync_q      <= sync_d;
      deb_level_q <= deb_level_d;
      deb_cnt_q   <= deb_cnt_d;
      edge_q      <= edge_d;
      period_q    <= period_d;
      state_q     <= state_d;
      div_state_q <= div_state_d;
      div_cnt_q   <= div_cnt_d;
      div_rem_q   <= div_rem_d;
      div_quo_q   <= div_quo_d;
      div_den_q   <= div_den_d;
      velo_q      <= velo_d;
      peri_q      <= peri_d;
      valid_q     <= valid_d;
      stalled_q   <= stalled_d;
    end
  end

  assign meas.velo       = velo_q;
  assign meas.peri_num   = peri_q;
  assign meas.meas_valid = valid_q;
  assign meas.stalled    = stalled_q;

endmodule
